instruction_fetch_unit: RTL

//  CPU-side reader of the 32x8 instruction ROM. Drives the 5-bit ROM address, assembles
//  1- or 2-byte instructions (opcode byte + optional immediate), and presents each one to
//  the decode/execute stage over a valid/ready handshake. Handles branch redirects and HALT.

---
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads the 32x8 instruction ROM, assembles 1- or 2-byte
// instructions and hands them to the decoder over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 8,
    parameter logic [15:0] TWO_BYTE = 16'h0038,
    parameter logic [3:0]  HALT_OP  = 4'h1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_imm,
    output logic              instr_two_byte,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              restart,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPERAND,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [DATA_W-1:0]   opcode_q;
    logic [DATA_W-1:0]   imm_q;
    logic                two_byte_q;
    logic [ADDR_W-1:0]   instr_pc_q;
    logic                valid_q;
    logic                halted_q;
    logic [3:0]          fetch_nib;
    logic [3:0]          issue_nib;

    // PC wraps naturally at 2^ADDR_W.
    assign pc_d      = pc_q + 1'b1;
    assign fetch_nib = imem_data[7:4];
    assign issue_nib = opcode_q[7:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            opcode_q   <= '0;
            imm_q      <= '0;
            two_byte_q <= 1'b0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else if (state_q != S_HALT && branch_valid) begin
            // Redirect drops whatever is in flight; a same-cycle accept already happened.
            pc_q    <= branch_target;
            valid_q <= 1'b0;
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    opcode_q   <= imem_data;
                    instr_pc_q <= pc_q;
                    pc_q       <= pc_d;
                    if (TWO_BYTE[fetch_nib]) begin
                        two_byte_q <= 1'b1;
                        state_q    <= S_OPERAND;
                    end else begin
                        two_byte_q <= 1'b0;
                        imm_q      <= '0;
                        valid_q    <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_OPERAND: begin
                    imm_q   <= imem_data;
                    pc_q    <= pc_d;
                    valid_q <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (issue_nib == HALT_OP) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (restart) begin
                        pc_q     <= '0;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_addr      = pc_q;
    assign instr_valid    = valid_q;
    assign instr_opcode   = opcode_q;
    assign instr_imm      = imm_q;
    assign instr_two_byte = two_byte_q;
    assign instr_pc       = instr_pc_q;
    assign halted         = halted_q;

endmodule
